// File: rtl/display_manager_n.sv
// Seven-segment display manager for the vending machine: shows credit in decimal via a
// sequential double-dabble converter, overridden by timed vend and blinking error messages.
module display_manager_n #(
  parameter int unsigned NUM_ITEMS    = 4,
  parameter int unsigned CREDIT_W     = 8,
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned HOLD_CYCLES  = 20,
  parameter int unsigned BLINK_CYCLES = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CREDIT_W-1:0]     credit,
  input  logic [NUM_ITEMS-1:0]    item_vend,
  input  logic                    error,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic [1:0]              mode,
  output logic                    busy
);

  // Enough BCD digits for any CREDIT_W value, plus at least one beyond the display for overflow
  localparam int unsigned BcdNeed   = CREDIT_W * 3 / 10 + 2;
  localparam int unsigned BcdDigits = (BcdNeed > NUM_DIGITS + 1) ? BcdNeed : NUM_DIGITS + 1;
  localparam int unsigned BcdW      = 4 * BcdDigits;
  localparam int unsigned SrW       = BcdW + CREDIT_W;
  localparam int unsigned StepW     = $clog2(CREDIT_W + 1);
  localparam int unsigned HoldW     = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BlinkW    = $clog2(BLINK_CYCLES + 1);
  localparam int unsigned SegW      = 7 * NUM_DIGITS;

  localparam logic [StepW-1:0]  LastStep  = StepW'(CREDIT_W);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    StCredit = 2'd0,
    StVend   = 2'd1,
    StError  = 2'd2
  } state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Converter state
  logic [CREDIT_W-1:0] cap_q, cap_d;
  logic [SrW-1:0]      sr_q, sr_d, sr_adj;
  logic [StepW-1:0]    step_q, step_d;
  logic                busy_q, busy_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;

  // Display state
  state_e              state_q, state_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [BlinkW-1:0]   blink_q, blink_d;
  logic                vis_q, vis_d;
  logic [3:0]          item_q, item_d;
  logic [SegW-1:0]     segs_q, segs_d;

  logic [SegW-1:0]     cred_segs;
  logic                ovf;
  logic                lead;
  logic [3:0]          dig;
  logic                vend_any;
  logic [3:0]          vend_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q   <= '0;
      sr_q    <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
      state_q <= StCredit;
      hold_q  <= '0;
      blink_q <= '0;
      vis_q   <= 1'b1;
      item_q  <= '0;
      segs_q  <= {{(SegW-7){1'b0}}, 7'h3F};
    end else begin
      cap_q   <= cap_d;
      sr_q    <= sr_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      vis_q   <= vis_d;
      item_q  <= item_d;
      segs_q  <= segs_d;
    end
  end

  // A changed credit always reloads, so a stale conversion can never reach bcd_q
  always_comb begin
    cap_d  = cap_q;
    sr_d   = sr_q;
    step_d = step_q;
    busy_d = busy_q;
    bcd_d  = bcd_q;
    sr_adj = sr_q;
    if (credit != cap_q) begin
      cap_d  = credit;
      sr_d   = {{BcdW{1'b0}}, credit};
      step_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (step_q == LastStep) begin
        bcd_d  = sr_q[SrW-1 -: BcdW];
        busy_d = 1'b0;
      end else begin
        for (int k = 0; k < int'(BcdDigits); k++) begin
          if (sr_adj[CREDIT_W + 4*k +: 4] >= 4'd5) begin
            sr_adj[CREDIT_W + 4*k +: 4] = sr_adj[CREDIT_W + 4*k +: 4] + 4'd3;
          end
        end
        sr_d   = {sr_adj[SrW-2:0], 1'b0};
        step_d = step_q + 1'b1;
      end
    end
  end

  always_comb begin
    cred_segs = '0;
    ovf       = 1'b0;
    lead      = 1'b1;
    dig       = '0;
    for (int k = int'(NUM_DIGITS); k < int'(BcdDigits); k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) ovf = 1'b1;
    end
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      dig = bcd_q[4*k +: 4];
      if (dig != 4'd0 || k == 0) lead = 1'b0;
      cred_segs[7*k +: 7] = lead ? 7'h00 : seg7(dig);
    end
    if (ovf) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) cred_segs[7*k +: 7] = 7'h40;
    end
  end

  // Lowest set bit wins
  always_comb begin
    vend_any = |item_vend;
    vend_idx = '0;
    for (int i = int'(NUM_ITEMS) - 1; i >= 0; i--) begin
      if (item_vend[i]) vend_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    vis_d   = vis_q;
    item_d  = item_q;
    segs_d  = cred_segs;

    if (error) begin
      state_d = StError;
      hold_d  = '0;
      blink_d = '0;
      vis_d   = 1'b1;
    end else if (vend_any && state_q != StError) begin
      state_d = StVend;
      hold_d  = '0;
      item_d  = vend_idx;
    end else if (state_q != StCredit) begin
      if (hold_q == HoldLast) begin
        state_d = StCredit;
        hold_d  = '0;
      end else begin
        hold_d = hold_q + 1'b1;
        if (blink_q == BlinkLast) begin
          blink_d = '0;
          vis_d   = ~vis_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end
    end

    // Segments follow the next state so they change on the edge that samples the pulse
    case (state_d)
      StVend: begin
        segs_d      = '0;
        segs_d[6:0] = seg7(item_d + 4'd1);
      end
      StError: begin
        segs_d = '0;
        if (vis_d) begin
          for (int k = 0; k < int'(NUM_DIGITS) - 1; k++) segs_d[7*k +: 7] = 7'h50;
          segs_d[SegW-1 -: 7] = 7'h79;
        end
      end
      default: segs_d = cred_segs;
    endcase
  end

  assign segs = segs_q;
  assign mode = state_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_display_manager_n.sv
// Directed bench for display_manager_n: default 3-digit instance plus a 2-digit instance
// for overflow dashes.
module tb_display_manager_n;

  logic        clk;
  logic        reset;
  logic [7:0]  credit;
  logic [3:0]  item_vend;
  logic        error;
  logic [20:0] segs;
  logic [1:0]  mode;
  logic        busy;

  logic [7:0]  credit2;
  logic [13:0] segs2;
  logic [1:0]  mode2;
  logic        busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int seen60;

  localparam logic [20:0] Seg0   = {7'h00, 7'h00, 7'h3F};
  localparam logic [20:0] Seg100 = {7'h06, 7'h3F, 7'h3F};
  localparam logic [20:0] Seg60  = {7'h00, 7'h7D, 7'h3F};
  localparam logic [20:0] Seg56  = {7'h00, 7'h6D, 7'h7D};
  localparam logic [20:0] Seg7   = {7'h00, 7'h00, 7'h07};
  localparam logic [20:0] Seg200 = {7'h5B, 7'h3F, 7'h3F};
  localparam logic [20:0] SegErr = {7'h79, 7'h50, 7'h50};

  display_manager_n dut (
    .clk       (clk),
    .reset     (reset),
    .credit    (credit),
    .item_vend (item_vend),
    .error     (error),
    .segs      (segs),
    .mode      (mode),
    .busy      (busy)
  );

  display_manager_n #(
    .NUM_DIGITS (2)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .credit    (credit2),
    .item_vend (4'b0000),
    .error     (1'b0),
    .segs      (segs2),
    .mode      (mode2),
    .busy      (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    credit    = 8'd0;
    credit2   = 8'd0;
    item_vend = 4'b0000;
    error     = 1'b0;
    #1;
    check("rst_segs", segs, Seg0);
    check("rst_mode", mode, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_segs2", segs2, 14'h003F);
    tick();
    reset = 1'b0;
    tick();

    // credit 100: busy across E0..E8, latch at E9, shown at E10
    credit = 8'd100;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("busy_run", busy, 1'b1);
    end
    tick();
    check("busy_done", busy, 1'b0);
    check("no_early", segs, Seg0);
    tick();
    check("show_100", segs, Seg100);

    credit = 8'd60;
    repeat (11) tick();
    check("show_60", segs, Seg60);

    credit = 8'd56;
    repeat (11) tick();
    check("show_56", segs, Seg56);

    // Restart: 60 requested, changed to 7 during the 4th conversion cycle
    credit = 8'd60;
    repeat (4) tick();
    credit = 8'd7;
    seen60 = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (segs == Seg60) seen60++;
    end
    check("no_stale_60", seen60, 0);
    check("show_7", segs, Seg7);

    // Vend item 1 -> "2" for 20 cycles
    item_vend = 4'b0110;
    tick();
    item_vend = 4'b0000;
    check("vend_mode", mode, 2'd1);
    check("vend_segs", segs, {7'h00, 7'h00, 7'h5B});
    repeat (19) tick();
    check("vend_hold_end", mode, 2'd1);
    tick();
    check("vend_back_mode", mode, 2'd0);
    check("vend_back_segs", segs, Seg7);

    // Re-vend at cycle 10 restarts hold
    item_vend = 4'b0110;
    tick();
    item_vend = 4'b0000;
    repeat (9) tick();
    item_vend = 4'b1000;
    tick();
    item_vend = 4'b0000;
    check("revend_segs", segs, {7'h00, 7'h00, 7'h66});
    repeat (19) tick();
    check("revend_hold", mode, 2'd1);
    tick();
    check("revend_back", mode, 2'd0);

    // Error during vend, with a vend pulse ignored mid-error
    item_vend = 4'b0001;
    tick();
    item_vend = 4'b0000;
    check("vend0_segs", segs, {7'h00, 7'h00, 7'h06});
    repeat (3) tick();
    error = 1'b1;
    tick();
    error = 1'b0;
    check("err_mode", mode, 2'd2);
    check("err_segs", segs, SegErr);
    for (int k = 1; k <= 20; k++) begin
      if (k == 12) item_vend = 4'b0100;
      tick();
      item_vend = 4'b0000;
      check("err_blink_mode", mode, (k < 20) ? 2'd2 : 2'd0);
      check("err_blink_segs", segs, (k >= 20) ? Seg7 : (((k / 5) % 2 == 0) ? SegErr : 21'h0));
    end

    // Simultaneous error and vend: error wins; a second error restarts counters
    error     = 1'b1;
    item_vend = 4'b0001;
    tick();
    error     = 1'b0;
    item_vend = 4'b0000;
    check("err_wins", mode, 2'd2);
    repeat (6) tick();
    error = 1'b1;
    tick();
    error = 1'b0;
    check("err_restart_vis", segs, SegErr);
    repeat (19) tick();
    check("err_restart_hold", mode, 2'd2);
    tick();
    check("err_restart_back", mode, 2'd0);

    // Asynchronous reset mid-conversion
    credit = 8'd200;
    tick();
    tick();
    check("mid_conv_busy", busy, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_segs", segs, Seg0);
    check("async_rst_mode", mode, 2'd0);
    check("async_rst_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    repeat (11) tick();
    check("show_200", segs, Seg200);

    // Two-digit instance: overflow dashes, then 99
    credit2 = 8'd150;
    repeat (11) tick();
    check("ovf_dash", segs2, {7'h40, 7'h40});
    credit2 = 8'd99;
    repeat (11) tick();
    check("show_99", segs2, {7'h6F, 7'h6F});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
